// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian-side crossing controller paired with the vehicle traffic light
// Ports:
//   clk, rst_n    clock; asynchronous active-low reset
//   button        raw pedestrian push-button (asynchronous to clk)
//   veh_red       vehicle red lamp; veh_yellow monitored only; veh_green vehicle green lamp
//   veh_clock     vehicle phase countdown (8-bit unsigned)
//   pass_request  asks the vehicle controller to shorten green while a request is pending
//   req_pending   a qualified press is latched and not yet served
//   walk          WALK lamp; dont_walk DONT_WALK lamp (flashes near the end of red)
//   ped_count     countdown shown to pedestrians (vehicle clock while walking/flashing)
module ped_crossing_ctrl #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CLEAR_CYC    = 2,
    parameter int MIN_WALK     = 4,
    parameter int FLASH_THRESH = 3,
    parameter int FLASH_HALF   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    input  logic       veh_red,
    input  logic       veh_yellow,
    input  logic       veh_green,
    input  logic [7:0] veh_clock,
    output logic       pass_request,
    output logic       req_pending,
    output logic       walk,
    output logic       dont_walk,
    output logic [7:0] ped_count
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_WALK  = 3'd3;
    localparam logic [2:0] S_FLASH = 3'd4;
    localparam logic [7:0] DB_MAX   = 8'(DEBOUNCE_CYC);
    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYC - 1);
    localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYC - 1);
    localparam logic [7:0] FL_LAST  = 8'(FLASH_HALF - 1);
    localparam logic [7:0] MIN_W    = 8'(MIN_WALK);
    localparam logic [7:0] FLASH_T  = 8'(FLASH_THRESH);
    logic [1:0] sync;
    logic [7:0] deb_cnt;
    logic       press_evt;
    logic       red_q;
    logic [2:0] state;
    logic [2:0] nxt;
    logic [7:0] clr_cnt;
    logic [7:0] fl_cnt;
    logic       unused_yellow;
    // Yellow has no control role; yellow+red is simply red.
    assign unused_yellow = veh_yellow;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = press_evt ? S_WAIT : S_IDLE;
            // Start on a fresh red, or on an ongoing red with enough time left to cross.
            S_WAIT:  nxt = (veh_red && (!red_q || veh_clock >= MIN_W)) ? S_CLEAR : S_WAIT;
            S_CLEAR: nxt = (clr_cnt == CLR_LAST) ? S_WALK : S_CLEAR;
            S_WALK:  nxt = (veh_clock <= FLASH_T) ? S_FLASH : S_WALK;
            S_FLASH: nxt = (veh_clock == 8'd0) ? S_IDLE : S_FLASH;
            default: nxt = S_IDLE;
        endcase
        // Losing red while the crossing is committed always wins.
        if (!veh_red && (state == S_CLEAR || state == S_WALK || state == S_FLASH))
            nxt = S_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync         <= 2'b00;
            deb_cnt      <= 8'd0;
            press_evt    <= 1'b0;
            red_q        <= 1'b0;
            state        <= S_IDLE;
            clr_cnt      <= 8'd0;
            fl_cnt       <= 8'd0;
            pass_request <= 1'b0;
            req_pending  <= 1'b0;
            walk         <= 1'b0;
            dont_walk    <= 1'b1;
            ped_count    <= 8'd0;
        end else begin
            sync         <= {sync[0], button};
            deb_cnt      <= !sync[1] ? 8'd0 : (deb_cnt == DB_MAX ? deb_cnt : deb_cnt + 8'd1);
            // Fires only on the step into saturation, so a held button yields one event.
            press_evt    <= sync[1] && deb_cnt == DB_LAST;
            red_q        <= veh_red;
            state        <= nxt;
            clr_cnt      <= (state == S_CLEAR) ? clr_cnt + 8'd1 : 8'd0;
            pass_request <= req_pending & veh_green;
            if (nxt == S_WALK && state != S_WALK)
                req_pending <= 1'b0;
            else if (press_evt && (state == S_IDLE || state == S_WAIT))
                req_pending <= 1'b1;
            walk      <= nxt == S_WALK;
            ped_count <= (nxt == S_WALK || nxt == S_FLASH) ? veh_clock : 8'd0;
            if (nxt != S_FLASH) begin
                fl_cnt    <= 8'd0;
                dont_walk <= nxt != S_WALK;
            end else if (state != S_FLASH) begin
                fl_cnt    <= 8'd0;
                dont_walk <= 1'b1;
            end else if (fl_cnt == FL_LAST) begin
                fl_cnt    <= 8'd0;
                dont_walk <= ~dont_walk;
            end else begin
                fl_cnt    <= fl_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed and randomized bench for ped_crossing_ctrl with a behavioural model
module tb_ped_crossing_ctrl;
    localparam int DEB = 4, CLR = 2, MINW = 4, FTH = 3, FH = 1;
    localparam int M_IDLE = 0, M_WAIT = 1, M_CLEAR = 2, M_WALK = 3, M_FLASH = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button = 1'b0;
    logic       veh_red = 1'b0;
    logic       veh_yellow = 1'b0;
    logic       veh_green = 1'b0;
    logic [7:0] veh_clock = 8'd0;
    logic       pass_request, req_pending, walk, dont_walk;
    logic [7:0] ped_count;
    int total = 0;
    int bad = 0;
    // behavioural model state
    bit   hist [0:15];
    int   mode, clear_left, flash_age;
    bit   m_press, red_prev, m_req, m_pass, m_walk, m_dw;
    int   m_ped;
    ped_crossing_ctrl dut (
        .clk(clk), .rst_n(rst_n), .button(button), .veh_red(veh_red),
        .veh_yellow(veh_yellow), .veh_green(veh_green), .veh_clock(veh_clock),
        .pass_request(pass_request), .req_pending(req_pending), .walk(walk),
        .dont_walk(dont_walk), .ped_count(ped_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        foreach (hist[i]) hist[i] = 1'b0;
        mode = M_IDLE; clear_left = 0; flash_age = 0;
        m_press = 0; red_prev = 0; m_req = 0; m_pass = 0; m_walk = 0; m_dw = 1; m_ped = 0;
    endtask
    // A press is a run of exactly DEB synchronized highs; sync delay puts the run two samples back.
    function automatic bit press_seen();
        for (int i = 2; i < DEB + 2; i++) if (!hist[i]) return 1'b0;
        return !hist[DEB + 2];
    endfunction
    task automatic model_edge();
        int nm;
        if (!rst_n) begin model_reset(); return; end
        for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = button;
        nm = mode;
        if (!veh_red && mode >= M_CLEAR) nm = M_IDLE;
        else if (mode == M_IDLE && m_press) nm = M_WAIT;
        else if (mode == M_WAIT && veh_red && (!red_prev || int'(veh_clock) >= MINW)) begin
            nm = M_CLEAR; clear_left = CLR;
        end else if (mode == M_CLEAR) begin
            if (clear_left == 1) nm = M_WALK; else clear_left--;
        end else if (mode == M_WALK && int'(veh_clock) <= FTH) nm = M_FLASH;
        else if (mode == M_FLASH && veh_clock == 0) nm = M_IDLE;
        m_pass = m_req & veh_green;
        if (nm == M_WALK && mode != M_WALK) m_req = 0;
        else if (m_press && (mode == M_IDLE || mode == M_WAIT)) m_req = 1;
        flash_age = (nm == M_FLASH && mode == M_FLASH) ? flash_age + 1 : 0;
        m_walk = nm == M_WALK;
        m_dw = (nm == M_FLASH) ? ((flash_age / FH) % 2 == 0) : (nm != M_WALK);
        m_ped = (nm == M_WALK || nm == M_FLASH) ? int'(veh_clock) : 0;
        red_prev = veh_red;
        m_press = press_seen();
        mode = nm;
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("walk", walk, m_walk);
        chk("dont_walk", dont_walk, m_dw);
        chk("ped_count", ped_count, m_ped);
        chk("req_pending", req_pending, m_req);
        chk("pass_request", pass_request, m_pass);
        chk("lamp_exclusive", walk & dont_walk, 0);
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    int vph, vleft, blen;
    initial begin
        model_reset();
        ticks(3);
        chk("rst_walk", walk, 0);
        chk("rst_dont_walk", dont_walk, 1);
        chk("rst_req", req_pending, 0);
        chk("rst_pass", pass_request, 0);
        chk("rst_ped", ped_count, 0);
        rst_n = 1'b1;
        veh_green = 1'b1; veh_clock = 8'd40;
        ticks(2);
        // bounce then steady press
        button = 1; tick(); button = 0; tick(); button = 1; tick(); button = 0; tick();
        button = 1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("bounce_req", req_pending, k == 7);
        end
        tick();
        chk("green_pass_on", pass_request, 1);
        ticks(3);
        button = 0;
        chk("single_event_req", req_pending, 1);
        veh_green = 0; tick();
        chk("green_pass_off", pass_request, 0);
        // full crossing
        veh_red = 1; veh_clock = 8'd10;
        ticks(2);
        chk("clear_walk", walk, 0);
        chk("clear_dw", dont_walk, 1);
        tick();
        chk("walk_on", walk, 1);
        chk("walk_ped", ped_count, 10);
        chk("walk_req_cleared", req_pending, 0);
        for (int c = 9; c >= 0; c--) begin
            veh_clock = 8'(c);
            tick();
            if (c == 3) chk("flash_entry_dw", dont_walk, 1);
            if (c == 2) chk("flash_toggle_dw", dont_walk, 0);
        end
        chk("cross_end_dw", dont_walk, 1);
        chk("cross_end_ped", ped_count, 0);
        // late request during a short red
        veh_clock = 8'd2;
        button = 1; ticks(7); button = 0;
        ticks(3);
        chk("late_req", req_pending, 1);
        chk("late_walk", walk, 0);
        veh_red = 0; veh_clock = 8'd0; ticks(2);
        veh_red = 1; veh_clock = 8'd20; ticks(3);
        chk("late_served", walk, 1);
        // safety: red lost mid-walk
        veh_clock = 8'd7; tick();
        chk("safety_pre_ped", ped_count, 7);
        veh_red = 0; tick();
        chk("safety_walk", walk, 0);
        chk("safety_dw", dont_walk, 1);
        chk("safety_ped", ped_count, 0);
        // presses during walk ignored, then reset mid-flash
        button = 1; ticks(7); button = 0; ticks(2);
        veh_red = 1; veh_clock = 8'd12; ticks(3);
        chk("walk2_on", walk, 1);
        button = 1; ticks(8); button = 0; ticks(2);
        chk("walk_press_ignored", req_pending, 0);
        veh_clock = 8'd3; ticks(2);
        chk("flash2_dw", dont_walk, 0);
        rst_n = 0; #1;
        model_reset();
        chk("async_rst_walk", walk, 0);
        chk("async_rst_dw", dont_walk, 1);
        chk("async_rst_req", req_pending, 0);
        chk("async_rst_ped", ped_count, 0);
        ticks(2);
        rst_n = 1;
        // randomized traffic and button activity
        veh_red = 0; vph = 2; vleft = 0; blen = 0;
        for (int n = 0; n < 4000; n++) begin
            if (vleft == 0) begin
                vph = (vph + 1) % 3;
                vleft = (vph == 1) ? 3 : int'($urandom_range(4, 20));
            end
            if (vph == 2 && $urandom_range(0, 15) == 0) begin
                vph = 0; vleft = int'($urandom_range(4, 20));
            end
            veh_green = vph == 0;
            veh_red = vph == 2;
            veh_yellow = vph == 1 || (vph == 2 && $urandom_range(0, 3) == 0);
            veh_clock = 8'(vleft - 1);
            vleft--;
            if (blen == 0) begin
                button = ~button;
                blen = int'($urandom_range(1, 10));
            end
            blen--;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
